// File: rtl/sr_switch_conditioner.sv
// Switch conditioner: 2-flop synchronizer and counter debounce per channel, plus edge pulses and S/R conflict flag.
// Latency DEBOUNCE_CYCLES+2 edges from a raw change to the clean output; no backpressure, every input is always accepted.
module sr_switch_conditioner #(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int CNT_W           = 20
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [2:0] sw_raw,
  output logic       s_clean,
  output logic       r_clean,
  output logic       e_clean,
  output logic [2:0] rise,
  output logic [2:0] fall,
  output logic       sr_conflict
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [2:0]       sync1_q, sync2_q;
  logic [2:0]       clean_q, clean_d;
  logic [2:0]       rise_q, rise_d;
  logic [2:0]       fall_q, fall_d;
  logic [CNT_W-1:0] cnt_q [3];
  logic [CNT_W-1:0] cnt_d [3];

  // Counter only runs while the synchronized level disagrees with clean.
  always_comb begin
    clean_d = clean_q;
    rise_d  = '0;
    fall_d  = '0;
    for (int i = 0; i < 3; i++) begin
      cnt_d[i] = '0;
      if (sync2_q[i] != clean_q[i]) begin
        if (cnt_q[i] == CNT_MAX) begin
          clean_d[i] = sync2_q[i];
          rise_d[i]  = sync2_q[i];
          fall_d[i]  = ~sync2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
      clean_q <= '0;
      rise_q  <= '0;
      fall_q  <= '0;
      for (int i = 0; i < 3; i++) cnt_q[i] <= '0;
    end else begin
      sync1_q <= sw_raw;
      sync2_q <= sync1_q;
      clean_q <= clean_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
      for (int i = 0; i < 3; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  assign s_clean     = clean_q[0];
  assign r_clean     = clean_q[1];
  assign e_clean     = clean_q[2];
  assign rise        = rise_q;
  assign fall        = fall_q;
  assign sr_conflict = clean_q[0] & clean_q[1];

endmodule

// File: tb/tb_sr_switch_conditioner.sv
// Randomized plus directed bench for sr_switch_conditioner, checked per cycle against a window-based reference model.
module tb_sr_switch_conditioner;

  localparam int D = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [2:0] sw_raw;
  logic       s_clean, r_clean, e_clean, sr_conflict;
  logic [2:0] rise, fall;

  int checks = 0;
  int errors = 0;

  sr_switch_conditioner #(.DEBOUNCE_CYCLES(D), .CNT_W(3)) dut (
    .clk(clk), .rst_n(rst_n), .sw_raw(sw_raw),
    .s_clean(s_clean), .r_clean(r_clean), .e_clean(e_clean),
    .rise(rise), .fall(fall), .sr_conflict(sr_conflict)
  );

  always #5 clk = ~clk;

  // Expected vector: {sr_conflict, fall, rise, e, r, s}
  logic [9:0] exp_q [$];
  logic [2:0] m_clean;
  logic [2:0] raw_hist [$];
  logic [2:0] s2_hist [$];

  function automatic logic [9:0] dut_vec();
    return {sr_conflict, fall, rise, e_clean, r_clean, s_clean};
  endfunction

  task automatic check(input string name, input logic [9:0] act, input logic [9:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got {conf,fall,rise,clean}=%b required %b at t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference: a clean bit flips when the last D synchronized samples all disagree with it.
  task automatic model_edge();
    logic [2:0] s2, rise_e, fall_e;
    logic       all_diff;
    rise_e = '0;
    fall_e = '0;
    if (!rst_n) begin
      m_clean = '0;
      raw_hist.delete();
      s2_hist.delete();
    end else begin
      s2 = (raw_hist.size() >= 2) ? raw_hist[raw_hist.size()-2] : 3'b000;
      raw_hist.push_back(sw_raw);
      if (raw_hist.size() > 3) void'(raw_hist.pop_front());
      s2_hist.push_back(s2);
      if (s2_hist.size() > D) void'(s2_hist.pop_front());
      for (int i = 0; i < 3; i++) begin
        if (s2_hist.size() == D) begin
          all_diff = 1'b1;
          for (int k = 0; k < D; k++)
            if (s2_hist[k][i] == m_clean[i]) all_diff = 1'b0;
          if (all_diff) begin
            m_clean[i] = ~m_clean[i];
            rise_e[i]  = m_clean[i];
            fall_e[i]  = ~m_clean[i];
          end
        end
      end
    end
    exp_q.push_back({m_clean[0] & m_clean[1], fall_e, rise_e, m_clean});
  endtask

  task automatic step(input logic [2:0] raw, input logic rst);
    @(negedge clk);
    sw_raw = raw;
    rst_n  = rst;
    model_edge();
  endtask

  task automatic hold(input logic [2:0] raw, input int n);
    for (int k = 0; k < n; k++) step(raw, 1'b1);
  endtask

  // Reset asserted between edges: outputs must clear before the next edge.
  task automatic reset_pulse(input logic [2:0] raw, input int low_cycles);
    @(negedge clk);
    sw_raw = raw;
    rst_n  = 1'b0;
    #1;
    check("async_reset", dut_vec(), 10'b0);
    model_edge();
    for (int k = 1; k < low_cycles; k++) step(raw, 1'b0);
  endtask

  initial begin : monitor
    logic [9:0] e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("cycle", dut_vec(), e);
      end
    end
  end

  initial begin : stimulus
    int budget;
    logic [2:0] v;
    sw_raw  = 3'b000;
    rst_n   = 1'b0;
    m_clean = '0;
    #2;
    check("reset_state", dut_vec(), 10'b0);
    for (int k = 0; k < 3; k++) step(3'b000, 1'b0);

    // Reset with all switches on
    hold(3'b111, 10);
    reset_pulse(3'b111, 2);
    hold(3'b111, 10);
    // Clean set S and E
    hold(3'b000, 10);
    hold(3'b101, 10);
    // Bounce rejection on R, then a stable press
    hold(3'b000, 10);
    hold(3'b010, 3);
    hold(3'b000, 2);
    hold(3'b010, 3);
    hold(3'b000, 4);
    hold(3'b010, 10);
    // Conflict
    hold(3'b000, 10);
    hold(3'b001, 10);
    hold(3'b011, 10);
    hold(3'b010, 10);
    // Reset mid-debounce on E
    hold(3'b000, 10);
    hold(3'b100, 4);
    reset_pulse(3'b100, 2);
    hold(3'b100, 10);
    // Simultaneous
    hold(3'b000, 10);
    hold(3'b111, 10);

    // Random bouncing with occasional resets
    for (int n = 0; n < 300; n++) begin
      if ($urandom_range(0, 29) == 0) begin
        reset_pulse(3'($urandom), $urandom_range(1, 3));
      end else begin
        v = 3'($urandom);
        hold(v, $urandom_range(1, 7));
      end
    end
    hold(3'b000, 10);

    budget = 0;
    while (exp_q.size() != 0 && budget < 10) begin
      @(posedge clk);
      #2;
      budget++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expected entries left, required 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
